irq_claim_arbiter: RTL and testbench
====================================

Name: irq_claim_arbiter

Overview:
- Per-target interrupt scheduler that sits behind the irq router.
- Takes one target's NumIntrSrc-wide slice of the routed interrupts and latches each source in a gateway.
- Presents a single irq line to the target core and hands out source IDs on claim.
- Uses round-robin arbitration and holds each claimed source in service until the core signals completion.

Parameters:
- NumIntrSrc, 16, number of interrupt sources routed to this target (>=2).
- IdWidth, $clog2(NumIntrSrc+1), width of the source ID. ID 0 means "none"; source i has ID i+1.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; synchronous, active-low
- irqs_i  in  NumIntrSrc  level-sensitive interrupt lines for this target
- irq_o  out  1  target interrupt request; high while any source is PENDING
- claim_i  in  1  one-cycle claim pulse from the target
- claim_valid_o  out  1  one-cycle pulse carrying the claim response
- claim_id_o  out  IdWidth  claimed ID, valid with claim_valid_o; 0 when nothing is pending
- complete_i  in  1  one-cycle completion pulse
- complete_id_i  in  IdWidth  ID being completed
- complete_err_o  out  1  one-cycle pulse when a completion is invalid

Behaviour:
- Reset: on clk_i edge with rst_ni=0, all state is cleared.
  - Every gateway goes to IDLE and the RR pointer goes to 0.
  - irq_o, claim_valid_o, claim_id_o and complete_err_o all read 0 in the cycle after reset.
  - Reset mid-operation discards all PENDING/INSERVICE state, with no completion required.
- Per-source gateway FSM (states IDLE, PENDING, INSERVICE):
  - IDLE -> PENDING when irqs_i[i]=1 at the clock edge.
  - PENDING is sticky: it holds even if irqs_i[i] drops, until claimed.
  - PENDING -> INSERVICE when the source wins a claim.
  - INSERVICE -> IDLE on complete_i with complete_id_i == i+1.
  - A level still high after completion re-enters PENDING on the next edge (one cycle in IDLE).
  - While INSERVICE, irqs_i[i] is ignored.
- irq_o is the combinational OR of the PENDING state bits. Latency: source edge at cycle t gives irq_o high during cycle t+1.
- Claim: claim_i sampled at edge t; arbitration uses the PENDING set registered before edge t.
  - Round-robin winner: lowest index >= ptr that is PENDING, wrapping from NumIntrSrc-1 to 0.
  - At edge t the winner becomes INSERVICE, claim_valid_o=1 and claim_id_o=winner+1 (visible in cycle t+1).
  - ptr becomes (winner+1) mod NumIntrSrc.
  - No PENDING source: claim_valid_o=1, claim_id_o=0, ptr unchanged.
  - claim_valid_o and claim_id_o return to 0 the following cycle unless claim_i is pulsed again.
  - Back-to-back claims in consecutive cycles are legal; each sees the state updated by the previous one.
- Complete: sampled at the edge; an INSERVICE source is cleared at that edge.
  - complete_id_i=0, >NumIntrSrc, or naming a non-INSERVICE source: no state change, complete_err_o=1 for one cycle.
- Any number of sources may be INSERVICE at once.
- Simultaneous claim_i and complete_i: both are processed at the same edge.
  - The completing source is not eligible for that claim, since it is INSERVICE before the edge.
  - A source completing and newly asserting at the same edge returns to IDLE; it goes PENDING one edge later.
- Source newly asserting in the same cycle as claim_i: not eligible for that claim; it becomes PENDING at that edge.
- Width rules: ID arithmetic is IdWidth bits; ptr is $clog2(NumIntrSrc) bits with explicit wrap, not relying on power-of-two overflow.

Test Plan:
- Reset then idle: irqs_i=0, claim_i pulsed -> claim_valid_o=1, claim_id_o=0; irq_o=0; ptr stays 0.
- Single source: irqs_i[3]=1 at cycle 10 -> irq_o=1 at cycle 11.
  - Claim at 12 -> claim_id_o=4 at 13, irq_o=0.
  - complete_id_i=4 with irqs_i[3] still 1 -> irq_o back to 1 two edges later.
- Round-robin: sources 0, 5, 15 pending, three consecutive claims -> IDs 1, 6, 16.
  - Fourth claim after re-pending source 0 -> ID 1 (wrap), ptr=1.
- Sticky pending: pulse irqs_i[7] for one cycle, then claim -> claim_id_o=8.
- Invalid completes each give complete_err_o=1 for one cycle with no state change:
  - complete_id_i=0;
  - complete_id_i=17;
  - complete_id_i=8 when source 7 is IDLE.
- Simultaneous claim + complete: source 2 INSERVICE and PENDING, source 9 PENDING, ptr=0; claim together with complete_id_i=3 -> claim_id_o=10.
- Reset mid-operation: source 2 in service and 4 pending -> after reset everything is IDLE and irq_o=0.
  - complete_id_i=3 afterwards -> complete_err_o=1.

Source files
------------

// File: rtl/irq_claim_arbiter.sv
// Per-target interrupt gateway bank with round-robin claim arbitration.
// Each source is latched IDLE -> PENDING -> INSERVICE and released on completion.
module irq_claim_arbiter #(
  parameter int NumIntrSrc = 16,
  parameter int IdWidth    = $clog2(NumIntrSrc + 1)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NumIntrSrc-1:0] irqs_i,
  output logic               irq_o,
  input  logic               claim_i,
  output logic               claim_valid_o,
  output logic [IdWidth-1:0] claim_id_o,
  input  logic               complete_i,
  input  logic [IdWidth-1:0] complete_id_i,
  output logic               complete_err_o
);

  localparam int PtrW = $clog2(NumIntrSrc);

  typedef enum logic [1:0] {
    GW_IDLE,
    GW_PEND,
    GW_INSVC
  } gw_e;

  gw_e                  gw_q [NumIntrSrc];
  gw_e                  gw_d [NumIntrSrc];
  logic [PtrW-1:0]      ptr_q, ptr_d;
  logic                 claim_valid_q, claim_valid_d;
  logic [IdWidth-1:0]   claim_id_q, claim_id_d;
  logic                 complete_err_q, complete_err_d;

  logic [NumIntrSrc-1:0] pend;
  logic [NumIntrSrc-1:0] cand;
  logic                  found;
  logic [PtrW-1:0]       win;
  logic                  comp_hit;

  always_comb begin
    for (int i = 0; i < NumIntrSrc; i++) begin
      pend[i] = (gw_q[i] == GW_PEND);
    end
  end

  // Round-robin: prefer pending sources at or above ptr, otherwise wrap to the lowest.
  always_comb begin
    cand  = pend & ({NumIntrSrc{1'b1}} << ptr_q);
    if (cand == '0) begin
      cand = pend;
    end
    found = 1'b0;
    win   = '0;
    for (int i = NumIntrSrc - 1; i >= 0; i--) begin
      if (cand[i]) begin
        found = 1'b1;
        win   = PtrW'(i);
      end
    end
  end

  always_comb begin
    gw_d           = gw_q;
    ptr_d          = ptr_q;
    claim_valid_d  = 1'b0;
    claim_id_d     = '0;
    comp_hit       = 1'b0;

    for (int i = 0; i < NumIntrSrc; i++) begin
      if (gw_q[i] == GW_IDLE && irqs_i[i]) begin
        gw_d[i] = GW_PEND;
      end
      if (complete_i && gw_q[i] == GW_INSVC && complete_id_i == IdWidth'(i + 1)) begin
        gw_d[i]  = GW_IDLE;
        comp_hit = 1'b1;
      end
    end
    complete_err_d = complete_i && !comp_hit;

    // Winner comes from the pre-edge PENDING set, so a source that is completing
    // or newly asserting this cycle can never be claimed here.
    if (claim_i) begin
      claim_valid_d = 1'b1;
      if (found) begin
        gw_d[win]  = GW_INSVC;
        claim_id_d = IdWidth'(win) + IdWidth'(1);
        ptr_d      = (win == PtrW'(NumIntrSrc - 1)) ? '0 : win + PtrW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumIntrSrc; i++) begin
        gw_q[i] <= GW_IDLE;
      end
      ptr_q          <= '0;
      claim_valid_q  <= 1'b0;
      claim_id_q     <= '0;
      complete_err_q <= 1'b0;
    end else begin
      gw_q           <= gw_d;
      ptr_q          <= ptr_d;
      claim_valid_q  <= claim_valid_d;
      claim_id_q     <= claim_id_d;
      complete_err_q <= complete_err_d;
    end
  end

  assign irq_o          = |pend;
  assign claim_valid_o  = claim_valid_q;
  assign claim_id_o     = claim_id_q;
  assign complete_err_o = complete_err_q;

endmodule

// File: tb/tb_irq_claim_arbiter.sv
// Directed bench for irq_claim_arbiter; claim/error responses checked through scoreboard queues.
module tb_irq_claim_arbiter;
  localparam int N  = 16;
  localparam int IW = 5;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic [N-1:0]  irqs_i = '0;
  logic          irq_o;
  logic          claim_i = 1'b0;
  logic          claim_valid_o;
  logic [IW-1:0] claim_id_o;
  logic          complete_i = 1'b0;
  logic [IW-1:0] complete_id_i = '0;
  logic          complete_err_o;

  int checks = 0;
  int errors = 0;
  int claim_q[$];
  int err_q[$];

  irq_claim_arbiter #(.NumIntrSrc(N)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .irqs_i(irqs_i), .irq_o(irq_o),
    .claim_i(claim_i), .claim_valid_o(claim_valid_o), .claim_id_o(claim_id_o),
    .complete_i(complete_i), .complete_id_i(complete_id_i),
    .complete_err_o(complete_err_o)
  );

  always #5 clk_i = ~clk_i;

  // Each expectation is pushed just after the edge that should produce it,
  // so it is due at the very next falling edge.
  always @(negedge clk_i) begin
    if (claim_q.size() > 0 || claim_valid_o) begin
      int exp;
      checks++;
      exp = (claim_q.size() > 0) ? claim_q.pop_front() : -1;
      if (exp < 0) begin
        errors++;
        $display("FAIL claim_unexpected got valid=%0d id=%0d want no response", claim_valid_o, claim_id_o);
      end else if (!claim_valid_o || int'(claim_id_o) != exp) begin
        errors++;
        $display("FAIL claim_id got valid=%0d id=%0d want valid=1 id=%0d", claim_valid_o, claim_id_o, exp);
      end
    end
    if (err_q.size() > 0 || complete_err_o) begin
      int exp;
      checks++;
      exp = (err_q.size() > 0) ? err_q.pop_front() : 0;
      if (complete_err_o !== 1'(exp)) begin
        errors++;
        $display("FAIL complete_err got %0d want %0d", complete_err_o, exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, got, exp);
    end
  endtask

  task automatic do_claim(int exp);
    claim_i = 1'b1;
    tick();
    claim_q.push_back(exp);
    claim_i = 1'b0;
  endtask

  task automatic do_complete(int id, bit err);
    complete_i    = 1'b1;
    complete_id_i = IW'(id);
    tick();
    if (err) err_q.push_back(1);
    complete_i    = 1'b0;
    complete_id_i = '0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
  endtask

  initial begin
    tick();
    do_reset();
    chk("rst_irq", 32'(irq_o), 0);
    chk("rst_claim_valid", 32'(claim_valid_o), 0);
    chk("rst_claim_id", 32'(claim_id_o), 0);
    chk("rst_err", 32'(complete_err_o), 0);

    // Idle claim returns ID 0.
    do_claim(0);
    chk("idle_irq", 32'(irq_o), 0);
    tick();

    // Single source 3.
    irqs_i[3] = 1'b1;
    tick();
    chk("single_irq_rise", 32'(irq_o), 1);
    do_claim(4);
    chk("single_irq_claimed", 32'(irq_o), 0);
    tick();
    chk("insvc_ignores_level", 32'(irq_o), 0);
    do_complete(4, 0);
    chk("after_complete_idle", 32'(irq_o), 0);
    tick();
    chk("repend_after_complete", 32'(irq_o), 1);
    do_claim(4);
    irqs_i = '0;
    do_complete(4, 0);
    chk("clean_after_single", 32'(irq_o), 0);

    // Round-robin from ptr 0.
    do_reset();
    irqs_i = N'(1) | (N'(1) << 5) | (N'(1) << 15);
    tick();
    irqs_i = '0;
    do_claim(1);
    do_claim(6);
    do_claim(16);
    chk("rr_none_left", 32'(irq_o), 0);
    do_complete(1, 0);
    irqs_i[0] = 1'b1;
    tick();
    irqs_i = '0;
    do_claim(1);
    do_complete(1, 0);
    irqs_i = N'(3);
    tick();
    irqs_i = '0;
    do_claim(2);
    do_claim(1);
    do_claim(0);
    do_complete(1, 0);
    do_complete(2, 0);
    do_complete(6, 0);
    do_complete(16, 0);

    // Sticky pending on a one-cycle pulse.
    irqs_i[7] = 1'b1;
    tick();
    irqs_i = '0;
    tick();
    tick();
    chk("sticky_irq", 32'(irq_o), 1);
    do_claim(8);
    do_complete(8, 0);

    // Invalid completions.
    do_complete(0, 1);
    do_complete(17, 1);
    do_complete(8, 1);
    chk("invalid_no_change", 32'(irq_o), 0);
    do_claim(0);

    // Simultaneous claim + complete with ptr steered back to 0.
    do_reset();
    irqs_i = N'(1) << 2 | N'(1) << 15;
    tick();
    irqs_i = N'(1) << 2;
    do_claim(3);
    do_claim(16);
    irqs_i[9] = 1'b1;
    tick();
    irqs_i[9] = 1'b0;
    claim_i       = 1'b1;
    complete_i    = 1'b1;
    complete_id_i = IW'(3);
    tick();
    claim_q.push_back(10);
    claim_i       = 1'b0;
    complete_i    = 1'b0;
    complete_id_i = '0;
    chk("simul_src2_idle", 32'(irq_o), 0);
    tick();
    chk("simul_src2_repend", 32'(irq_o), 1);

    // Reset mid-operation.
    do_claim(3);
    irqs_i = N'(1) << 4;
    tick();
    irqs_i = '0;
    chk("pre_reset_irq", 32'(irq_o), 1);
    do_reset();
    chk("midreset_irq", 32'(irq_o), 0);
    chk("midreset_claim_valid", 32'(claim_valid_o), 0);
    do_complete(3, 1);
    do_claim(0);

    tick();
    tick();
    checks++;
    if (claim_q.size() != 0 || err_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d left want 0", claim_q.size() + err_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end
endmodule
